// File: rtl/node_pkg.sv
// Shared definitions for the sequential recursion / minimisation nodes.
package node_pkg;

    // Default datapath width for generated nodes.
    localparam int NODE_WIDTH = 16;

    // Control states shared by the sequential nodes.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } node_state_t;

endpackage : node_pkg

// File: rtl/node_r_step.sv
// Step function g(k,acc,a,b) = acc + b for the recursion node, plus the
// counter decrement and zero detect that drive the control FSM.
module node_r_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic [WIDTH-1:0] acc_nxt_o,
    output logic [WIDTH-1:0] cnt_nxt_o,
    output logic             cnt_zero_o
);

    // One iteration: wrapping add and counter decrement.
    always_comb begin
        acc_nxt_o  = acc_i + b_i;
        cnt_nxt_o  = cnt_i - WIDTH'(1);
        cnt_zero_o = (cnt_i == '0);
    end

endmodule : node_r_step

// File: rtl/node_r_mulacc.sv
// Primitive-recursion node R(f,g): RES = IN0 + IN1*IN2 (mod 2^WIDTH),
// computed by IN2 iterated additions under an ST/RD level handshake.
module node_r_mulacc
    import node_pkg::*;
#(
    parameter int WIDTH = NODE_WIDTH
) (
    input  logic             RST,
    input  logic             ST,
    input  logic             CLK,
    output logic             RD,
    output logic [WIDTH-1:0] RES,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2
);

    node_state_t      state_q, state_d;
    logic [WIDTH-1:0] acc_q, b_q, cnt_q, res_q;
    logic [WIDTH-1:0] acc_nxt, cnt_nxt;
    logic             cnt_zero;

    node_r_step #(.WIDTH(WIDTH)) u_step (
        .acc_i      (acc_q),
        .b_i        (b_q),
        .cnt_i      (cnt_q),
        .acc_nxt_o  (acc_nxt),
        .cnt_nxt_o  (cnt_nxt),
        .cnt_zero_o (cnt_zero)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a low ST in RUN aborts even on the finishing edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ST) state_d = RUN;
            RUN:     if (!ST) state_d = IDLE;
                     else if (cnt_zero) state_d = DONE;
            DONE:    if (!ST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: RD decodes registered state only, RES is a register.
    always_comb begin
        RD  = (state_q == DONE);
        RES = res_q;
    end

    // Datapath: operands captured only on IDLE->RUN, iterate while RUN holds.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (ST) begin
                    acc_q <= IN0;
                    b_q   <= IN1;
                    cnt_q <= IN2;
                end
                RUN: if (ST) begin
                    if (cnt_zero) begin
                        res_q <= acc_q;
                    end else begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : node_r_mulacc

// File: tb/tb_node_r_mulacc.sv
// Self-checking bench for node_r_mulacc: directed table, hand-written
// corner sequences and randomized runs against an arithmetic reference.
module tb_node_r_mulacc;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ST  = 1'b0;
    logic        RD;
    logic [15:0] RES, IN0, IN1, IN2;

    int checks = 0;
    int errors = 0;

    node_r_mulacc #(.WIDTH(16)) dut (
        .RST (RST), .ST (ST), .CLK (CLK), .RD (RD), .RES (RES),
        .IN0 (IN0), .IN1 (IN1), .IN2 (IN2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] in0, in1, in2, res;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Behavioural reference: closed-form multiply-accumulate.
    function automatic logic [15:0] ref_res(input logic [15:0] a, b, n);
        logic [31:0] p;
        p = 32'(a) + 32'(b) * 32'(n);
        return p[15:0];
    endfunction

    // Full handshake: return to IDLE, start, wait for RD (bounded), hold, release.
    task automatic run(input logic [15:0] a, b, n, input logic [15:0] exp, input string nm);
        int k;
        int lim;
        bit seen;
        @(negedge CLK); ST = 1'b0;
        @(negedge CLK);
        IN0 = a; IN1 = b; IN2 = n; ST = 1'b1;
        k = 0; seen = 0; lim = int'(n) + 40;
        while (!seen && k < lim) begin
            @(negedge CLK); k++;
            if (RD) seen = 1;
        end
        check({nm, "_lat"}, k, int'(n) + 2);
        check({nm, "_res"}, RES, exp);
        IN0 = 16'($urandom); IN1 = 16'($urandom); IN2 = 16'($urandom);
        repeat (3) @(negedge CLK);
        check({nm, "_hold_rd"}, RD, 1);
        check({nm, "_hold_res"}, RES, exp);
        ST = 1'b0;
        @(negedge CLK);
        check({nm, "_rd_fall"}, RD, 0);
        check({nm, "_res_kept"}, RES, exp);
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] a, b, n;
        bit rd_seen;

        IN0 = '0; IN1 = '0; IN2 = '0;
        tbl[0] = '{16'd5,    16'd3,      16'd4,    16'd17};
        tbl[1] = '{16'h1234, 16'h0007,   16'd0,    16'h1234};
        tbl[2] = '{16'hFFFF, 16'd2,      16'd1,    16'h0001};
        tbl[3] = '{16'h0000, 16'h8000,   16'd3,    16'h8000};
        tbl[4] = '{16'h00FF, 16'h0101,   16'h0040, 16'h413F};

        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_rd", RD, 0);
        check("rst_res", RES, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_rd", RD, 0);

        // Directed table.
        foreach (tbl[i]) run(tbl[i].in0, tbl[i].in1, tbl[i].in2, tbl[i].res, $sformatf("tbl%0d", i));

        // Input isolation: operands change right after E0.
        @(negedge CLK); ST = 1'b0;
        @(negedge CLK); IN0 = 16'd1; IN1 = 16'd1; IN2 = 16'd3; ST = 1'b1;
        @(negedge CLK); IN0 = 16'hFFFF; IN1 = 16'hFFFF; IN2 = 16'hFFFF;
        repeat (3) @(negedge CLK);
        check("iso_rd_early", RD, 0);
        @(negedge CLK);
        check("iso_rd", RD, 1);
        check("iso_res", RES, 4);
        prev = 16'd4;

        // Abort mid-run: ST dropped before E0+4.
        @(negedge CLK); ST = 1'b0;
        @(negedge CLK); IN0 = 16'd0; IN1 = 16'd1; IN2 = 16'd10; ST = 1'b1;
        repeat (4) @(negedge CLK);
        ST = 1'b0;
        rd_seen = 0;
        repeat (15) begin @(negedge CLK); if (RD) rd_seen = 1; end
        check("abort_rd", rd_seen, 0);
        check("abort_res", RES, prev);
        run(16'd2, 16'd2, 16'd2, 16'd6, "rerun");
        prev = 16'd6;

        // ST falls on the edge that would finish: abort wins.
        @(negedge CLK); IN0 = 16'd9; IN1 = 16'd9; IN2 = 16'd2; ST = 1'b1;
        repeat (3) @(negedge CLK);
        ST = 1'b0;
        rd_seen = 0;
        repeat (6) begin @(negedge CLK); if (RD) rd_seen = 1; end
        check("race_rd", rd_seen, 0);
        check("race_res", RES, prev);

        // Asynchronous reset mid-run clears outputs before any edge.
        @(negedge CLK); IN0 = 16'd1; IN1 = 16'd1; IN2 = 16'd20; ST = 1'b1;
        repeat (5) @(negedge CLK);
        #2 RST = 1'b1;
        #1 check("arst_rd", RD, 0);
        check("arst_res", RES, 0);
        @(negedge CLK);
        check("arst_hold_res", RES, 0);
        IN0 = 16'd3; IN1 = 16'd4; IN2 = 16'd5;
        RST = 1'b0;
        begin
            int k;
            k = 0; rd_seen = 0;
            while (!rd_seen && k < 50) begin
                @(negedge CLK); k++;
                if (RD) rd_seen = 1;
            end
            check("arst_restart_lat", k, 7);
            check("arst_restart_res", RES, 16'd23);
        end

        // Randomized runs against the arithmetic reference.
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            n = 16'($urandom_range(0, 30));
            run(a, b, n, ref_res(a, b, n), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_node_r_mulacc
